// File: rtl/sha_pipe_slice_chain.sv
// Chain of DEPTH valid/ready skid-buffer slices carrying WIDTH-bit words between SHA-256 stages.
// Every output is driven from a flop; the chain also provides a synchronous flush and an occupancy count.
module sha_pipe_slice_chain #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CNT_W = $clog2(2 * DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [CNT_W-1:0] occupancy
);

  if (DEPTH < 1) begin : g_depth_check
    $error("sha_pipe_slice_chain: DEPTH must be >= 1");
  end

  // Per-slice state exported for neighbour links and the occupancy sum
  logic             main_valid_w   [DEPTH];
  logic [WIDTH-1:0] main_data_w    [DEPTH];
  logic             ready_w        [DEPTH];
  logic             main_valid_n_w [DEPTH];
  logic             skid_valid_n_w [DEPTH];
  logic [CNT_W-1:0] occ_next;

  for (genvar k = 0; k < DEPTH; k++) begin : g_slice
    logic             main_valid, skid_valid, ready_q;
    logic [WIDTH-1:0] main_data, skid_data;
    logic             main_valid_n, skid_valid_n;
    logic [WIDTH-1:0] main_data_n, skid_data_n;
    logic             up_valid, down_ready, accept, drain;
    logic [WIDTH-1:0] up_data;

    if (k == 0) begin : g_head
      assign up_valid = in_valid;
      assign up_data  = in_data;
    end else begin : g_link
      assign up_valid = main_valid_w[k-1];
      assign up_data  = main_data_w[k-1];
    end

    if (k == DEPTH - 1) begin : g_tail
      assign down_ready = out_ready;
    end else begin : g_pass
      assign down_ready = ready_w[k+1];
    end

    assign accept = up_valid & ready_q;
    assign drain  = main_valid & down_ready;

    // EMPTY / ONE / FULL transitions, encoded by (main_valid, skid_valid)
    always_comb begin
      main_valid_n = main_valid;
      main_data_n  = main_data;
      skid_valid_n = skid_valid;
      skid_data_n  = skid_data;
      if (skid_valid) begin
        if (drain) begin
          main_data_n  = skid_data;
          skid_valid_n = 1'b0;
        end
      end else if (main_valid) begin
        if (accept && drain) begin
          main_data_n = up_data;
        end else if (accept) begin
          skid_valid_n = 1'b1;
          skid_data_n  = up_data;
        end else if (drain) begin
          main_valid_n = 1'b0;
        end
      end else if (accept) begin
        main_valid_n = 1'b1;
        main_data_n  = up_data;
      end
    end

    always_ff @(posedge clock) begin
      if (reset || flush) begin
        main_valid <= 1'b0;
        skid_valid <= 1'b0;
        main_data  <= '0;
        skid_data  <= '0;
        ready_q    <= 1'b1;
      end else begin
        main_valid <= main_valid_n;
        skid_valid <= skid_valid_n;
        main_data  <= main_data_n;
        skid_data  <= skid_data_n;
        ready_q    <= !skid_valid_n;
      end
    end

    assign main_valid_w[k]   = main_valid;
    assign main_data_w[k]    = main_data;
    assign ready_w[k]        = ready_q;
    assign main_valid_n_w[k] = main_valid_n;
    assign skid_valid_n_w[k] = skid_valid_n;
  end

  // Occupancy register tracks the post-edge count of valid entries
  always_comb begin
    occ_next = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      occ_next = occ_next + CNT_W'(main_valid_n_w[i]) + CNT_W'(skid_valid_n_w[i]);
    end
  end

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      occupancy <= '0;
    end else begin
      occupancy <= occ_next;
    end
  end

  assign in_ready  = ready_w[0];
  assign out_valid = main_valid_w[DEPTH-1];
  assign out_data  = main_data_w[DEPTH-1];

endmodule

// File: tb/tb_sha_pipe_slice_chain.sv
// Directed bench for sha_pipe_slice_chain: a DEPTH=2/WIDTH=32 chain and a DEPTH=1/WIDTH=1 chain, each checked against a FIFO scoreboard.
module tb_sha_pipe_slice_chain;

  logic        clock = 1'b0;
  logic        reset, flush;
  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [31:0] a_in_data, a_out_data;
  logic [2:0]  a_occupancy;
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic        b_in_data, b_out_data;
  logic [1:0]  b_occupancy;

  always #5 clock = ~clock;

  sha_pipe_slice_chain #(.WIDTH(32), .DEPTH(2)) u_dut_a (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(a_in_valid), .in_data(a_in_data), .in_ready(a_in_ready),
    .out_valid(a_out_valid), .out_data(a_out_data), .out_ready(a_out_ready),
    .occupancy(a_occupancy)
  );

  sha_pipe_slice_chain #(.WIDTH(1), .DEPTH(1)) u_dut_b (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(b_in_valid), .in_data(b_in_data), .in_ready(b_in_ready),
    .out_valid(b_out_valid), .out_data(b_out_data), .out_ready(b_out_ready),
    .occupancy(b_occupancy)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] qa[$];
  logic        qb[$];
  int          a_acc = 0, a_pop = 0, b_acc = 0, b_pop = 0;
  int          b_max = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: score handshakes before the edge, check registered state after it
  task automatic tick();
    logic        a_in_f, a_out_f, b_in_f, b_out_f, a_hold, b_hold, eb, b_hold_data;
    logic [31:0] ea, a_hold_data;
    a_in_f  = a_in_valid & a_in_ready;
    a_out_f = a_out_valid & a_out_ready;
    b_in_f  = b_in_valid & b_in_ready;
    b_out_f = b_out_valid & b_out_ready;
    if (reset || flush) begin
      qa.delete();
      qb.delete();
    end else begin
      if (a_out_f) begin
        ea = (qa.size() != 0) ? qa.pop_front() : ~a_out_data;
        check("a_data", a_out_data, ea);
        a_pop++;
      end
      if (a_in_f) begin
        qa.push_back(a_in_data);
        a_acc++;
      end
      if (b_out_f) begin
        eb = (qb.size() != 0) ? qb.pop_front() : ~b_out_data;
        check("b_data", 32'(b_out_data), 32'(eb));
        b_pop++;
      end
      if (b_in_f) begin
        qb.push_back(b_in_data);
        b_acc++;
      end
    end
    a_hold = a_out_valid & !a_out_ready & !reset & !flush;
    b_hold = b_out_valid & !b_out_ready & !reset & !flush;
    a_hold_data = a_out_data;
    b_hold_data = b_out_data;
    @(posedge clock);
    #1;
    check("a_occ", 32'(a_occupancy), 32'(qa.size()));
    check("b_occ", 32'(b_occupancy), 32'(qb.size()));
    if (int'(b_occupancy) > b_max) b_max = int'(b_occupancy);
    if (a_hold) begin
      check("a_hold_valid", 32'(a_out_valid), 32'd1);
      check("a_hold_data", a_out_data, a_hold_data);
    end
    if (b_hold) begin
      check("b_hold_valid", 32'(b_out_valid), 32'd1);
      check("b_hold_data", 32'(b_out_data), 32'(b_hold_data));
    end
  endtask

  task automatic idle_inputs();
    a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_data = 1'b0; b_out_ready = 1'b1;
  endtask

  initial begin
    int base, pbase, first_in, last_in, first_out, last_out, nvalid;
    reset = 1'b1;
    flush = 1'b0;
    idle_inputs();
    tick();
    tick();
    reset = 1'b0;
    check("rst_a_in_ready", 32'(a_in_ready), 32'd1);
    check("rst_a_out_valid", 32'(a_out_valid), 32'd0);
    check("rst_a_out_data", a_out_data, 32'd0);
    check("rst_a_occ", 32'(a_occupancy), 32'd0);
    check("rst_b_in_ready", 32'(b_in_ready), 32'd1);

    // Back-to-back stream of 1..16 with no backpressure
    base = a_acc; pbase = a_pop;
    first_in = -1; last_in = -1; first_out = -1; last_out = -1; nvalid = 0;
    for (int i = 0; i < 24; i++) begin
      a_in_valid = (a_acc - base) < 16;
      a_in_data  = 32'(a_acc - base + 1);
      if (a_in_valid && a_in_ready) begin
        if (first_in < 0) first_in = i;
        last_in = i;
      end
      if (a_out_valid) begin
        if (first_out < 0) first_out = i;
        last_out = i;
        nvalid++;
      end
      tick();
    end
    check("t1_accepted", 32'(a_acc - base), 32'd16);
    check("t1_in_span", 32'(last_in - first_in), 32'd15);
    check("t1_latency", 32'(first_out - first_in), 32'd2);
    check("t1_out_span", 32'(last_out - first_out), 32'd15);
    check("t1_out_count", 32'(nvalid), 32'd16);
    check("t1_popped", 32'(a_pop - pbase), 32'd16);

    // Backpressure absorbs exactly 2*DEPTH words
    base = a_acc; pbase = a_pop;
    a_out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      a_in_valid = 1'b1;
      a_in_data  = 32'hA0 + 32'(a_acc - base);
      tick();
    end
    check("t2_accepted", 32'(a_acc - base), 32'd4);
    check("t2_in_ready", 32'(a_in_ready), 32'd0);
    check("t2_occ", 32'(a_occupancy), 32'd4);
    a_in_valid = 1'b0;
    a_out_ready = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    check("t2_drained", 32'(a_pop - pbase), 32'd4);
    check("t2_occ_empty", 32'(a_occupancy), 32'd0);

    // Toggling out_ready with random upstream valid over 1000 words
    base = a_acc; pbase = a_pop;
    for (int c = 0; c < 6000 && (a_acc - base) < 1000; c++) begin
      a_out_ready = c[0];
      a_in_valid  = 1'($urandom_range(1, 0));
      a_in_data   = a_in_valid ? 32'h1000 + 32'(a_acc - base) : 'x;
      tick();
    end
    a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    check("t3_accepted", 32'(a_acc - base), 32'd1000);
    check("t3_drained", 32'(a_pop - pbase), 32'd1000);

    // Flush with three words held and an input offered
    base = a_acc;
    a_out_ready = 1'b0;
    for (int i = 0; i < 10 && a_occupancy != 3'd3; i++) begin
      a_in_valid = 1'b1;
      a_in_data  = 32'hB0 + 32'(a_acc - base);
      tick();
    end
    check("t4_occ_pre", 32'(a_occupancy), 32'd3);
    flush = 1'b1; a_in_valid = 1'b1; a_in_data = 32'h0000DEAD; a_out_ready = 1'b1;
    tick();
    flush = 1'b0; a_in_valid = 1'b0; a_in_data = '0;
    check("t4_occ", 32'(a_occupancy), 32'd0);
    check("t4_out_valid", 32'(a_out_valid), 32'd0);
    check("t4_in_ready", 32'(a_in_ready), 32'd1);
    check("t4_out_data", a_out_data, 32'd0);
    pbase = a_pop;
    for (int i = 0; i < 6; i++) tick();
    check("t4_no_output", 32'(a_pop - pbase), 32'd0);

    // Reset with the chain full, then resume traffic
    a_out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      a_in_valid = 1'b1;
      a_in_data  = 32'hE0 + 32'(i);
      tick();
    end
    check("t5_occ_full", 32'(a_occupancy), 32'd4);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t5_in_ready", 32'(a_in_ready), 32'd1);
    check("t5_out_valid", 32'(a_out_valid), 32'd0);
    check("t5_out_data", a_out_data, 32'd0);
    check("t5_occ", 32'(a_occupancy), 32'd0);
    base = a_acc; pbase = a_pop;
    a_out_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      a_in_valid = (a_acc - base) < 8;
      a_in_data  = 32'hC0 + 32'(a_acc - base);
      tick();
    end
    a_in_valid = 1'b0;
    check("t5_resumed", 32'(a_pop - pbase), 32'd8);

    // Single-bit, single-slice chain
    b_out_ready = 1'b1; b_in_valid = 1'b1; b_in_data = 1'b1;
    tick();
    b_in_valid = 1'b0; b_in_data = 1'b0;
    check("t6_latency_valid", 32'(b_out_valid), 32'd1);
    check("t6_latency_data", 32'(b_out_data), 32'd1);
    tick();
    b_out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      b_in_valid = 1'b1;
      b_in_data  = 1'(i);
      tick();
    end
    check("t6_occ_full", 32'(b_occupancy), 32'd2);
    check("t6_in_ready", 32'(b_in_ready), 32'd0);
    for (int i = 0; i < 400; i++) begin
      b_in_valid  = 1'($urandom_range(1, 0));
      b_in_data   = 1'($urandom_range(1, 0));
      b_out_ready = 1'($urandom_range(1, 0));
      tick();
    end
    b_in_valid = 1'b0; b_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check("t6_balance", 32'(b_pop), 32'(b_acc));
    check("t6_max_occ", 32'(b_max), 32'd2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
